// File: rtl/enemy_life_fsm_bank.sv
// Per-slot enemy life/animation FSM bank: spawn, hit flash, explosion frames, vanish pulses, score.
// Optional macro ENEMY_HP_OUT_EN adds hp_o (life of the scanned slot) for a boss health bar.
module enemy_life_fsm_bank #(
    parameter int ENEMY_NUM         = 4,
    parameter int ENEMY_NUM_BIT_LEN = 2,
    parameter int LIFE              = 3,
    parameter int LIFE_BIT_LEN      = 2,
    parameter int DOWN_FRAMES       = 3,
    parameter int FRAME_BIT_LEN     = 3,
    parameter int TICK_MAX          = 4,
    parameter int TICK_BIT_LEN      = 2,
    parameter int SCORE             = 10,
    parameter int SCORE_BIT_LEN     = 8
) (
    input  logic                         clk_vga,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         trigger_i,
    input  logic [ENEMY_NUM_BIT_LEN-1:0] trigger_idx_i,
    input  logic                         curr_vali_i,
    input  logic [ENEMY_NUM_BIT_LEN-1:0] curr_idx_i,
    input  logic                         crash_bullet_i,
    input  logic                         crash_me_i,
    input  logic                         bomb_i,
    output logic                         visible_o,
    output logic [FRAME_BIT_LEN-1:0]     frame_sel_o,
    output logic [ENEMY_NUM-1:0]         disappear_o,
`ifdef ENEMY_HP_OUT_EN
    output logic [LIFE_BIT_LEN-1:0]      hp_o,
`endif
    output logic [SCORE_BIT_LEN-1:0]     add_score_o
);

    typedef enum logic [1:0] {UNVISUAL, NORMAL, HIT, DOWN} state_t;

    state_t                    state_q [ENEMY_NUM];
    state_t                    state_d [ENEMY_NUM];
    logic [LIFE_BIT_LEN-1:0]   life_q  [ENEMY_NUM];
    logic [LIFE_BIT_LEN-1:0]   life_d  [ENEMY_NUM];
    logic [FRAME_BIT_LEN-1:0]  d_q     [ENEMY_NUM];
    logic [FRAME_BIT_LEN-1:0]  d_d     [ENEMY_NUM];
    logic [ENEMY_NUM-1:0]      hit;
    logic [TICK_BIT_LEN-1:0]   tick_cnt_q;
    logic                      tick_q;
    logic                      tick_wrap;
    logic [SCORE_BIT_LEN-1:0]  score_d;
    int unsigned               pop;

    assign tick_wrap = (tick_cnt_q == TICK_BIT_LEN'(TICK_MAX - 1));

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
                state_q[i] <= UNVISUAL;
                life_q[i]  <= LIFE_BIT_LEN'(LIFE);
                d_q[i]     <= '0;
            end
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            add_score_o <= '0;
        end else begin
            state_q     <= state_d;
            life_q      <= life_d;
            d_q         <= d_d;
            add_score_o <= score_d;
            // tick register holds with the counter while frozen so a pending tick survives a pause
            if (en_i) begin
                tick_q     <= tick_wrap;
                tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
            hit[i] = en_i && curr_vali_i && (crash_bullet_i || crash_me_i) &&
                     (curr_idx_i == ENEMY_NUM_BIT_LEN'(i));
        end
    end

    always_comb begin
        disappear_o = '0;
        pop         = 0;
        for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
            state_d[i] = state_q[i];
            life_d[i]  = life_q[i];
            d_d[i]     = d_q[i];
            if (en_i) begin
                unique case (state_q[i])
                    UNVISUAL: begin
                        life_d[i] = LIFE_BIT_LEN'(LIFE);
                        if (trigger_i && trigger_idx_i == ENEMY_NUM_BIT_LEN'(i))
                            state_d[i] = NORMAL;
                    end
                    NORMAL: begin
                        if (hit[i] || bomb_i || life_q[i] == '0)
                            state_d[i] = HIT;
                    end
                    HIT: begin
                        if (tick_q) begin
                            if (life_q[i] == '0) begin
                                state_d[i] = DOWN;
                                d_d[i]     = '0;
                            end else begin
                                state_d[i] = NORMAL;
                            end
                        end
                    end
                    DOWN: begin
                        if (tick_q) begin
                            if (d_q[i] == FRAME_BIT_LEN'(DOWN_FRAMES - 1)) begin
                                state_d[i]     = UNVISUAL;
                                disappear_o[i] = 1'b1;
                            end else begin
                                d_d[i] = d_q[i] + 1'b1;
                            end
                        end
                    end
                endcase
                if (state_q[i] != UNVISUAL) begin
                    if (bomb_i)
                        life_d[i] = '0;
                    else if (hit[i] && state_q[i] != DOWN) begin
                        if (crash_me_i)
                            life_d[i] = '0;
                        else if (life_q[i] != '0)
                            life_d[i] = life_q[i] - 1'b1;
                    end
                end
            end
            pop = pop + {31'd0, disappear_o[i]};
        end
        score_d = SCORE_BIT_LEN'(pop * SCORE);
    end

    always_comb begin
        visible_o   = 1'b0;
        frame_sel_o = '0;
`ifdef ENEMY_HP_OUT_EN
        hp_o        = '0;
`endif
        for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
            if (curr_vali_i && curr_idx_i == ENEMY_NUM_BIT_LEN'(i) && state_q[i] != UNVISUAL) begin
                visible_o = 1'b1;
                case (state_q[i])
                    HIT:     frame_sel_o = FRAME_BIT_LEN'(1);
                    DOWN:    frame_sel_o = FRAME_BIT_LEN'(2) + d_q[i];
                    default: frame_sel_o = '0;
                endcase
`ifdef ENEMY_HP_OUT_EN
                hp_o = life_q[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_enemy_life_fsm_bank.sv
// Directed bench for enemy_life_fsm_bank: frame-based reference model checked every cycle plus literal pins.
module tb_enemy_life_fsm_bank;
    localparam int EN = 4, LF = 3, DF = 3, TM = 4, SC = 10;

    logic       clk_vga = 1'b0, rst = 1'b0, en_i = 1'b0, trigger_i = 1'b0;
    logic [1:0] trigger_idx_i = '0, curr_idx_i = '0;
    logic       curr_vali_i = 1'b0, crash_bullet_i = 1'b0, crash_me_i = 1'b0, bomb_i = 1'b0;
    logic       visible_o;
    logic [2:0] frame_sel_o;
    logic [3:0] disappear_o;
    logic [7:0] add_score_o;

    int checks = 0, failures = 0;

    enemy_life_fsm_bank #(
        .ENEMY_NUM(EN), .ENEMY_NUM_BIT_LEN(2), .LIFE(LF), .LIFE_BIT_LEN(2),
        .DOWN_FRAMES(DF), .FRAME_BIT_LEN(3), .TICK_MAX(TM), .TICK_BIT_LEN(2),
        .SCORE(SC), .SCORE_BIT_LEN(8)
    ) dut (
        .clk_vga(clk_vga), .rst(rst), .en_i(en_i), .trigger_i(trigger_i),
        .trigger_idx_i(trigger_idx_i), .curr_vali_i(curr_vali_i), .curr_idx_i(curr_idx_i),
        .crash_bullet_i(crash_bullet_i), .crash_me_i(crash_me_i), .bomb_i(bomb_i),
        .visible_o(visible_o), .frame_sel_o(frame_sel_o), .disappear_o(disappear_o),
        .add_score_o(add_score_o)
    );

    always #5 clk_vga = ~clk_vga;

    // Model: each slot is just its sprite frame (-1 = absent, 0 normal, 1 flash, 2.. explosion)
    int m_frame [EN];
    int m_life  [EN];
    int nf [EN];
    int nl [EN];
    int m_cnt = 0, m_tick = 0, m_score = 0;
    int mdis, mpop;
    bit mhit;

    function automatic int m_dis();
        int r = 0;
        if (en_i && m_tick != 0)
            for (int i = 0; i < EN; i++) if (m_frame[i] == DF + 1) r |= (1 << i);
        return r;
    endfunction

    function automatic int m_vis();
        return (curr_vali_i && int'(curr_idx_i) < EN && m_frame[curr_idx_i] >= 0) ? 1 : 0;
    endfunction

    function automatic int m_fsel();
        return (m_vis() != 0) ? m_frame[curr_idx_i] : 0;
    endfunction

    always @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EN; i++) begin m_frame[i] = -1; m_life[i] = LF; end
            m_cnt = 0; m_tick = 0; m_score = 0;
        end else begin
            mdis = m_dis();
            mpop = 0;
            for (int i = 0; i < EN; i++) mpop += (mdis >> i) & 1;
            m_score = (mpop * SC) % 256;
            if (en_i) begin
                for (int i = 0; i < EN; i++) begin
                    mhit  = curr_vali_i && (crash_bullet_i || crash_me_i) && int'(curr_idx_i) == i;
                    nf[i] = m_frame[i];
                    nl[i] = m_life[i];
                    if (m_frame[i] < 0) begin
                        nl[i] = LF;
                        if (trigger_i && int'(trigger_idx_i) == i) nf[i] = 0;
                    end else begin
                        if (m_frame[i] == 0) begin
                            if (mhit || bomb_i || m_life[i] == 0) nf[i] = 1;
                        end else if (m_tick != 0) begin
                            if (m_frame[i] == 1)           nf[i] = (m_life[i] == 0) ? 2 : 0;
                            else if (m_frame[i] == DF + 1) nf[i] = -1;
                            else                           nf[i] = m_frame[i] + 1;
                        end
                        if (bomb_i) nl[i] = 0;
                        else if (mhit && m_frame[i] <= 1)
                            nl[i] = crash_me_i ? 0 : (m_life[i] > 0 ? m_life[i] - 1 : 0);
                    end
                end
                for (int i = 0; i < EN; i++) begin m_frame[i] = nf[i]; m_life[i] = nl[i]; end
                m_tick = (m_cnt == TM - 1) ? 1 : 0;
                m_cnt  = (m_cnt + 1) % TM;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_vga) begin
        chk("model_visible", int'(visible_o), m_vis());
        chk("model_frame_sel", int'(frame_sel_o), m_fsel());
        chk("model_disappear", int'(disappear_o), m_dis());
        chk("model_add_score", int'(add_score_o), m_score);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk_vga); #1; end
    endtask

    // Follow the scanned slot until a vanish pulse: frame sequence as decimal digits, pulse mask, next score
    task automatic watch(input int maxc, output int seq, output int dis, output int score);
        int last = -1;
        seq = 0; dis = 0; score = -1;
        for (int k = 0; k < maxc && dis == 0; k++) begin
            if (visible_o && int'(frame_sel_o) != last) begin
                last = int'(frame_sel_o);
                seq  = seq * 10 + last;
            end
            if (disappear_o != '0) dis = int'(disappear_o);
            cyc(1);
        end
        if (dis != 0) score = int'(add_score_o);
    endtask

    task automatic wait_frame(input int f);
        int k = 0;
        while (int'(frame_sel_o) != f && k < 40) begin cyc(1); k++; end
        chk("wait_frame", int'(frame_sel_o), f);
    endtask

    int seq, dis, score;

    initial begin
        #1 rst = 1'b1; en_i = 1'b1; curr_vali_i = 1'b1; curr_idx_i = 2'd2;
        #3;
        chk("rst_visible", int'(visible_o), 0);
        chk("rst_frame", int'(frame_sel_o), 0);
        chk("rst_disappear", int'(disappear_o), 0);
        chk("rst_score", int'(add_score_o), 0);
        #14 rst = 1'b0;
        cyc(1);

        // spawn slot 2
        trigger_i = 1'b1; trigger_idx_i = 2'd2;
        cyc(1);
        trigger_i = 1'b0;
        #1;
        chk("spawn_visible", int'(visible_o), 1);
        chk("spawn_frame", int'(frame_sel_o), 0);
        chk("spawn_disappear", int'(disappear_o), 0);
        chk("spawn_score", int'(add_score_o), 0);

        // three bullet hits on slot 2
        for (int h = 0; h < 3; h++) begin
            crash_bullet_i = 1'b1;
            cyc(1);
            crash_bullet_i = 1'b0;
            chk("hit_flash", int'(frame_sel_o), 1);
            if (h < 2) begin
                cyc(2 * TM);
                chk("hit_recover", int'(frame_sel_o), 0);
            end
        end
        watch(40, seq, dis, score);
        chk("bullet_frames", seq, 1234);
        chk("bullet_disappear", dis, 4);
        chk("bullet_score", score, 10);
        cyc(1);
        chk("score_one_cycle", int'(add_score_o), 0);

        // crash_me on slot 1
        trigger_i = 1'b1; trigger_idx_i = 2'd1;
        cyc(1);
        trigger_i = 1'b0; curr_idx_i = 2'd1; crash_me_i = 1'b1;
        cyc(1);
        crash_me_i = 1'b0;
        watch(40, seq, dis, score);
        chk("crash_frames", seq, 1234);
        chk("crash_disappear", dis, 2);
        chk("crash_score", score, 10);

        // bomb three slots
        curr_idx_i = 2'd0;
        trigger_i = 1'b1;
        trigger_idx_i = 2'd0; cyc(1);
        trigger_idx_i = 2'd1; cyc(1);
        trigger_idx_i = 2'd3; cyc(1);
        trigger_i = 1'b0; bomb_i = 1'b1;
        cyc(1);
        bomb_i = 1'b0;
        watch(40, seq, dis, score);
        chk("bomb_frames", seq, 1234);
        chk("bomb_disappear", dis, 11);
        chk("bomb_score", score, 30);

        // retrigger live slot, then trigger + bomb on an absent slot
        trigger_i = 1'b1; trigger_idx_i = 2'd0;
        cyc(1);
        cyc(1);
        trigger_i = 1'b0;
        chk("retrigger_frame", int'(frame_sel_o), 0);
        trigger_i = 1'b1; trigger_idx_i = 2'd3; bomb_i = 1'b1;
        cyc(1);
        trigger_i = 1'b0; bomb_i = 1'b0; curr_idx_i = 2'd3;
        #1;
        chk("trig_bomb_visible", int'(visible_o), 1);
        chk("trig_bomb_frame", int'(frame_sel_o), 0);
        crash_bullet_i = 1'b1;
        cyc(1);
        crash_bullet_i = 1'b0;
        cyc(2 * TM);
        chk("trig_bomb_life", int'(frame_sel_o), 0);
        cyc(30);

        // freeze mid-explosion
        crash_me_i = 1'b1;
        cyc(1);
        crash_me_i = 1'b0;
        wait_frame(3);
        en_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("freeze_frame", int'(frame_sel_o), 3);
            chk("freeze_disappear", int'(disappear_o), 0);
        end
        en_i = 1'b1;
        watch(40, seq, dis, score);
        chk("resume_frames", seq, 34);
        chk("resume_disappear", dis, 8);
        chk("resume_score", score, 10);

        // async reset mid-explosion
        trigger_i = 1'b1; trigger_idx_i = 2'd2;
        cyc(1);
        trigger_i = 1'b0; curr_idx_i = 2'd2; crash_me_i = 1'b1;
        cyc(1);
        crash_me_i = 1'b0;
        wait_frame(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_visible", int'(visible_o), 0);
        chk("arst_frame", int'(frame_sel_o), 0);
        chk("arst_disappear", int'(disappear_o), 0);
        chk("arst_score", int'(add_score_o), 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
